// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Constants, opcodes and the IF/ID bundle.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
// Flush beats stall, stall beats load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE = NOP_WORD
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t bubble;

  assign bubble = '{instr: BUBBLE, pc4: 32'd0, valid: 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= bubble;
    end else if (flush) begin
      q <= bubble;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage.
// PC, next-PC select, alignment flag and fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  import mips_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic        kill;
  logic        take;
  if_id_t      d;
  if_id_t      q;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;

  // A redirect squashes the word fetched on the wrong path.
  assign kill = flush | redirect_valid;
  assign take = !kill && !stall;

  assign d = '{instr: imem_rdata, pc4: pc4, valid: 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      fetch_cnt    <= 32'd0;
    end else begin
      if (redirect_valid && redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;
      if (take)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  if_id_reg #(
    .BUBBLE(NOP_WORD)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(kill),
    .stall(stall),
    .d    (d),
    .q    (q)
  );

  assign if_id_instr = q.instr;
  assign if_id_pc4   = q.pc4;
  assign if_id_valid = q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// Directed plan steps followed by a randomized run against a model.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int n_pass;
  int n_total;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_cnt;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_000A;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("pc", imem_addr, m_pc);
    check("instr", if_id_instr, m_instr);
    check("pc4", if_id_pc4, m_pc4);
    check("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("misalign", {31'd0, misalign_err}, {31'd0, m_err});
    check("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  // One clock edge: advance the model from the inputs, then compare.
  task automatic cyc();
    logic [31:0] word;
    logic [31:0] nxt;
    @(posedge clk);
    word = mem(m_pc);
    nxt  = m_pc + 32'd4;
    if (flush || redirect_valid) begin
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = word;
      m_pc4   = nxt;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    if (redirect_valid) begin
      if (redirect_pc % 4 != 0) m_err = 1'b1;
      m_pc = redirect_pc - (redirect_pc % 4);
    end else if (!stall) begin
      m_pc = nxt;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle();
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    #1;
    check("rel_pc", imem_addr, 32'h0);

    // Free run from reset
    cyc();
    check("t1_instr0", if_id_instr, 32'h2001_0005);
    check("t1_pc4_0", if_id_pc4, 32'h4);
    check("t1_valid", {31'd0, if_id_valid}, 32'd1);
    cyc();
    check("t1_instr1", if_id_instr, 32'h2002_000A);
    check("t1_pc", imem_addr, 32'h8);
    check("t1_cnt", fetch_cnt, 32'd2);

    // Three-cycle stall at pc 8
    stall = 1'b1;
    repeat (3) cyc();
    check("t2_pc", imem_addr, 32'h8);
    check("t2_cnt", fetch_cnt, 32'd2);
    stall = 1'b0;
    cyc();
    check("t2_instr", if_id_instr, mem(32'h8));
    check("t2_pc4", if_id_pc4, 32'hC);
    check("t2_cnt3", fetch_cnt, 32'd3);

    // Redirect at pc 0xC
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cyc();
    check("t3_pc", imem_addr, 32'h40);
    check("t3_bubble", {31'd0, if_id_valid}, 32'd0);
    idle();
    cyc();
    check("t3_instr", if_id_instr, mem(32'h40));
    check("t3_pc4", if_id_pc4, 32'h44);

    // Redirect with stall, then flush with stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    stall          = 1'b1;
    cyc();
    check("t4_pc", imem_addr, 32'h80);
    check("t4_bubble", {31'd0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    flush          = 1'b1;
    cyc();
    check("t4_hold", imem_addr, 32'h80);
    check("t4_instr", if_id_instr, 32'h0);
    idle();
    cyc();

    // Misaligned target is forced aligned and flagged
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    cyc();
    check("t5_pc", imem_addr, 32'h40);
    check("t5_err", {31'd0, misalign_err}, 32'd1);
    idle();
    repeat (4) cyc();
    check("t5_sticky", {31'd0, misalign_err}, 32'd1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    idle();
    cyc();
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);

    // Asynchronous reset mid-stall at pc 0x20
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    cyc();
    idle();
    stall = 1'b1;
    cyc();
    check("t6_pc", imem_addr, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    cyc();
    check("t6_restart", if_id_instr, 32'h2001_0005);
    check("t6_pc", imem_addr, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(3) == 0);
      flush          = ($urandom_range(7) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(1) == 0)
        redirect_pc[1:0] = 2'b00;
      cyc();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
